// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter: grants one of NUM_REQ requesters per cycle and loads its lane into a shared DATA_W-bit register.
// Latency: 1 cycle; req/d_in sampled at edge N give gnt/q/q_valid/owner after edge N.
// Backpressure: none; requesters hold req until granted, and a locked burst is capped at MAX_HOLD loads.
// Build option: define ARB_FIXED_PRIO_EN to pin the scan start at index 0 (fixed priority).
module dff_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ-1:0]                           lock,
  input  logic [NUM_REQ*DATA_W-1:0]                    d_in,
  output logic [NUM_REQ-1:0]                           gnt,
  output logic [DATA_W-1:0]                            q,
  output logic                                         q_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] owner,
  output logic                                         busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                vld_q, vld_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       rr_q, rr_d;
  logic [HW-1:0]       hold_q, hold_d;

  // Arbitration scratch
  logic [NUM_REQ-1:0]  arb_req;
  logic                found;
  logic [OW-1:0]       win;
  logic [OW-1:0]       sel;
  logic                cont;

  // Next-state: burst continuation, release/re-arbitration, or fall back to IDLE
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    found   = 1'b0;
    win     = '0;
    sel     = owner_q;

    cont = (state_q == OWN) && req[owner_q] && lock[owner_q] &&
           (int'(hold_q) < MAX_HOLD - 1);

    // The releasing owner sits out one arbitration so others get a turn first
    arb_req = req;
    if (state_q == OWN) begin
      arb_req[owner_q] = 1'b0;
    end

    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && arb_req[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = OW'((int'(rr_q) + k) % NUM_REQ);
      end
    end

    if (cont) begin
      data_d = d_in[int'(owner_q)*DATA_W +: DATA_W];
      vld_d  = 1'b1;
      hold_d = hold_q + 1'b1;
    end else if (found || ((state_q == OWN) && req[owner_q])) begin
      // Masked owner only gets back in when nobody else is asking
      sel        = found ? win : owner_q;
      state_d    = OWN;
      gnt_d      = '0;
      gnt_d[sel] = 1'b1;
      owner_d    = sel;
      data_d     = d_in[int'(sel)*DATA_W +: DATA_W];
      vld_d      = 1'b1;
      hold_d     = '0;
`ifdef ARB_FIXED_PRIO_EN
      rr_d       = '0;
`else
      rr_d       = OW'((int'(sel) + 1) % NUM_REQ);
`endif
    end else begin
      state_d = IDLE;
      gnt_d   = '0;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      owner_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = vld_q;
  assign owner   = owner_q;
  assign busy    = (state_q == OWN);

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared DATA_W-bit D-register (reset-clearable flip-flop bank).
- Up to NUM_REQ requesters compete to load the register. The block grants one requester per cycle, muxes its data into the register, and reports the owner.
- A locked burst lets one requester keep ownership for up to MAX_HOLD consecutive loads.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each requester data lane.
- MAX_HOLD, 4, maximum consecutive load cycles in one locked burst (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NUM_REQ  per-requester load request; level, held until granted.
- lock  input  NUM_REQ  per-requester burst request; sampled only while that requester owns the register.
- d_in  input  NUM_REQ*DATA_W  packed data lanes; lane i = d_in[i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  registered one-hot grant; gnt[i]=1 in the cycle after d_in lane i was loaded.
- q  output  DATA_W  shared register contents.
- q_valid  output  1  1 for exactly those cycles following a load edge.
- owner  output  clog2(NUM_REQ) (min 1)  index of the last requester granted.
- busy  output  1  1 while in OWN state.

Behaviour:
- Reset (reset=0, async): gnt=0, q=0, q_valid=0, owner=0, busy=0, state=IDLE, rr_ptr=0, hold_cnt=0. All outputs are registered. Release is synchronous to the next clk edge.
- FSM states:
  - IDLE.
  - OWN: owns the register; tracks current winner w and hold_cnt.
- Arbitration (combinational, evaluated at each edge where arbitration is allowed):
  - Winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
- IDLE:
  - No req: stay in IDLE; gnt=0, q_valid=0, q holds its value.
  - Any req: go to OWN. Set gnt=onehot(w), owner=w, q=d_in lane w, q_valid=1, hold_cnt=0, rr_ptr=(w+1) mod NUM_REQ.
  - Latency: req sampled at edge N gives q/gnt/q_valid valid after edge N.
- OWN, continue burst when req[w]&&lock[w]&&hold_cnt<MAX_HOLD-1:
  - Load d_in lane w again; gnt unchanged; q_valid=1; hold_cnt++.
- OWN, otherwise (release):
  - Re-arbitrate in the same edge using the updated rr_ptr. req[w] is masked for this one arbitration, so the released owner cannot win back-to-back while others wait.
  - If another winner exists: load it as from IDLE (no bubble cycle).
  - If no other winner exists but req[w] is still 1: grant w again as a new burst (hold_cnt=0).
  - If no requester: go to IDLE; gnt=0, q_valid=0, busy=0.
- MAX_HOLD=1: lock has no effect; every grant lasts one cycle.
- Deassertion of req[w] mid-burst ends the burst at that edge (release rule applies).
- lock from non-owners is ignored.
- owner and q retain their last values in IDLE.
- Reset asserted mid-burst: everything returns to reset values immediately. q clears to 0 regardless of burst progress.

Optional Feature:
- ARB_FIXED_PRIO_EN defined:
  - rr_ptr is held at 0; the lowest-index active req always wins.
  - The back-to-back mask on release is still applied.
- ARB_FIXED_PRIO_EN undefined: round-robin behaviour as specified above.

Test Plan:
- Reset and idle:
  - Stimulus: reset=0 mid-operation with q=8'hA5 and busy=1.
  - Required: q=0, gnt=0, q_valid=0, owner=0, busy=0 asynchronously, before the next clk edge.
- Single request:
  - Stimulus: req=4'b0100, lane2=8'h3C for one cycle, lock=0.
  - Required after the edge: gnt=4'b0100, owner=2, q=8'h3C, q_valid=1.
  - Required the next cycle (req=0): IDLE, q_valid=0, q stays 8'h3C.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, lock=0, lanes = 8'h10, 8'h11, 8'h12, 8'h13.
  - Required: successive grants at owner 0,1,2,3,0 with q=8'h10,8'h11,8'h12,8'h13,8'h10; q_valid=1 continuously.
- Locked burst limit:
  - Stimulus: req=4'b0011, lock=4'b0001, MAX_HOLD=4.
  - Required: owner 0 for exactly 4 consecutive loads, then owner 1; no idle cycle between.
- Burst abort:
  - Stimulus: owner 1 locked, req[1] dropped after 2 loads while req[3]=1.
  - Required: the next edge grants owner 3, gnt=4'b1000.
- Fixed priority (ARB_FIXED_PRIO_EN defined):
  - Stimulus: req=4'b1010 held.
  - Required: owner alternates 1,3,1,3, since the mask forces handoff; with req=4'b0010 only, owner stays 1 every cycle.
